// File: rtl/dom1_skinny_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | dom1_skinny_pkg : shared types/constants for the masked SKINNY control   |
// | Revision 1.0                                                             |
// +--------------------------------------------------------------------------+
package dom1_skinny_pkg;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_WAIT_RND = 2'd1,
        ST_RUN      = 2'd2,
        ST_DONE     = 2'd3
    } state_t;

    localparam int          SKINNY_PHASES = 5;
    localparam logic [5:0]  RC_INIT       = 6'h01;
    localparam logic [5:0]  RC_LAST       = 6'h1a;

    // SKINNY round-constant LFSR: shift left, feed back rc5 ^ rc4 ^ 1.
    function automatic logic [5:0] rc_step(input logic [5:0] rc);
        return {rc[4:0], rc[5] ^ rc[4] ^ 1'b1};
    endfunction

endpackage
`default_nettype wire

// File: rtl/dom1_skinny_rc_lfsr.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | dom1_skinny_rc_lfsr : 6-bit round-constant LFSR with load and step      |
// | Revision 1.0                                                             |
// +--------------------------------------------------------------------------+
module dom1_skinny_rc_lfsr
    import dom1_skinny_pkg::*;
#(
    parameter logic [5:0] INIT = dom1_skinny_pkg::RC_INIT
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       load,
    input  logic       step,
    output logic [5:0] rc
);

    logic [5:0] rc_d;
    logic [5:0] rc_q;

    always_comb begin
        rc_d = rc_q;
        if (load) begin
            rc_d = INIT;
        end else if (step) begin
            rc_d = rc_step(rc_q);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rc_q <= INIT;
        end else begin
            rc_q <= rc_d;
        end
    end

    assign rc = rc_q;

endmodule
`default_nettype wire

// File: rtl/dom1_skinny_round_sched.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | dom1_skinny_round_sched : stall-capable round/phase sequencer with PRNG  |
// | handshake for the DOM-masked SKINNY-128-384+ datapath. Revision 1.0      |
// +--------------------------------------------------------------------------+
module dom1_skinny_round_sched
    import dom1_skinny_pkg::*;
#(
    parameter int         NUM_ROUNDS = 40,
    parameter logic [5:0] RC_INIT    = 6'h01
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     start,
    output logic                     start_ready,
    input  logic                     abort,
    output logic                     rnd_req,
    input  logic                     rnd_ack,
    output logic                     rnd_ld,
    output logic [SKINNY_PHASES-1:0] en,
    output logic [5:0]               rnd_cnst,
    output logic [5:0]               round,
    output logic                     busy,
    output logic                     done
);

    localparam logic [5:0]               LAST_ROUND = 6'(NUM_ROUNDS - 1);
    localparam logic [SKINNY_PHASES-1:0] PH_FIRST   = {{(SKINNY_PHASES-1){1'b0}}, 1'b1};

    state_t                   state_d, state_q;
    logic [SKINNY_PHASES-1:0] en_d, en_q;
    logic [5:0]               round_d, round_q;
    logic                     rc_load;
    logic                     rc_adv;
    logic                     last_phase;
    logic                     last_round;

    assign last_phase = en_q[SKINNY_PHASES-1];
    assign last_round = (round_q == LAST_ROUND);

    always_comb begin
        state_d = state_q;
        en_d    = en_q;
        round_d = round_q;
        rc_load = 1'b0;
        rc_adv  = 1'b0;
        if (abort) begin
            state_d = ST_IDLE;
            en_d    = '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (start) begin
                        state_d = ST_WAIT_RND;
                        round_d = '0;
                        rc_load = 1'b1;
                    end
                end
                ST_WAIT_RND: begin
                    if (rnd_ack) begin
                        state_d = ST_RUN;
                        en_d    = PH_FIRST;
                    end
                end
                ST_RUN: begin
                    if (!last_phase) begin
                        en_d = {en_q[SKINNY_PHASES-2:0], en_q[SKINNY_PHASES-1]};
                    end else if (last_round) begin
                        state_d = ST_DONE;
                        en_d    = '0;
                    end else begin
                        round_d = round_q + 6'd1;
                        rc_adv  = 1'b1;
                        // Prefetched word already here: next round starts without a bubble.
                        if (rnd_ack) begin
                            en_d = PH_FIRST;
                        end else begin
                            state_d = ST_WAIT_RND;
                            en_d    = '0;
                        end
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            en_q    <= '0;
            round_q <= '0;
        end else begin
            state_q <= state_d;
            en_q    <= en_d;
            round_q <= round_d;
        end
    end

    dom1_skinny_rc_lfsr #(
        .INIT (RC_INIT)
    ) u_rc_lfsr (
        .clk   (clk),
        .rst_n (rst_n),
        .load  (rc_load),
        .step  (rc_adv),
        .rc    (rnd_cnst)
    );

    assign rnd_req     = (state_q == ST_WAIT_RND) ||
                         ((state_q == ST_RUN) && last_phase && !last_round);
    assign rnd_ld      = rnd_req && rnd_ack;
    assign start_ready = (state_q == ST_IDLE);
    assign busy        = (state_q == ST_WAIT_RND) || (state_q == ST_RUN);
    assign done        = (state_q == ST_DONE);
    assign en          = en_q;
    assign round       = round_q;

endmodule
`default_nettype wire

// File: tb/tb_dom1_skinny_round_sched.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_dom1_skinny_round_sched : directed bench for the round scheduler      |
// | Revision 1.0                                                             |
// +--------------------------------------------------------------------------+
module tb_dom1_skinny_round_sched;

    localparam logic [5:0] RC_TAB [0:39] = '{
        6'h01, 6'h03, 6'h07, 6'h0f, 6'h1f, 6'h3e, 6'h3d, 6'h3b, 6'h37, 6'h2f,
        6'h1e, 6'h3c, 6'h39, 6'h33, 6'h27, 6'h0e, 6'h1d, 6'h3a, 6'h35, 6'h2b,
        6'h16, 6'h2c, 6'h18, 6'h30, 6'h21, 6'h02, 6'h05, 6'h0b, 6'h17, 6'h2e,
        6'h1c, 6'h38, 6'h31, 6'h23, 6'h06, 6'h0d, 6'h1b, 6'h36, 6'h2d, 6'h1a
    };

    logic       clk = 1'b0;
    logic       rst_n, start, abort, rnd_ack;
    logic       start_ready, rnd_req, rnd_ld, busy, done;
    logic [4:0] en;
    logic [5:0] rnd_cnst, round;

    logic       start1, abort1, rnd_ack1;
    logic       start_ready1, rnd_req1, rnd_ld1, busy1, done1;
    logic [4:0] en1;
    logic [5:0] rnd_cnst1, round1;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    always #5 clk = ~clk;

    dom1_skinny_round_sched #(.NUM_ROUNDS(40), .RC_INIT(6'h01)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .start_ready(start_ready),
        .abort(abort), .rnd_req(rnd_req), .rnd_ack(rnd_ack), .rnd_ld(rnd_ld),
        .en(en), .rnd_cnst(rnd_cnst), .round(round), .busy(busy), .done(done)
    );

    dom1_skinny_round_sched #(.NUM_ROUNDS(1), .RC_INIT(6'h01)) dut1 (
        .clk(clk), .rst_n(rst_n), .start(start1), .start_ready(start_ready1),
        .abort(abort1), .rnd_req(rnd_req1), .rnd_ack(rnd_ack1), .rnd_ld(rnd_ld1),
        .en(en1), .rnd_cnst(rnd_cnst1), .round(round1), .busy(busy1), .done(done1)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s cycle=%0d observed=%0h expected=%0h", tag, cyc, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_reset_values(input string tag);
        chk({tag, "_start_ready"}, 32'(start_ready), 32'd1);
        chk({tag, "_en"},          32'(en),          32'd0);
        chk({tag, "_rnd_req"},     32'(rnd_req),     32'd0);
        chk({tag, "_done"},        32'(done),        32'd0);
        chk({tag, "_busy"},        32'(busy),        32'd0);
        chk({tag, "_round"},       32'(round),       32'd0);
        chk({tag, "_rnd_cnst"},    32'(rnd_cnst),    32'h01);
    endtask

    // Full 40-round run; rnd_ack drops for stall_len cycles ahead of round stall_round.
    task automatic run_seq(input int stall_round, input int stall_len, input bit noise);
        int       done_c;
        int       ld_cnt;
        int       t0;
        int       exp_k;
        logic [4:0] exp_en;
        done_c = 202 + stall_len;
        ld_cnt = 0;
        cyc    = 0;
        start   = 1'b1;
        rnd_ack = 1'b1;
        #1;
        chk("accept_ready", 32'(start_ready), 32'd1);
        tick();
        start = 1'b0;
        for (int c = 1; c <= done_c + 2; c++) begin
            cyc     = c;
            rnd_ack = !((c >= 5*stall_round + 1) && (c <= 5*stall_round + stall_len));
            start   = noise && ((c == 60) || (c == done_c));
            #1;
            exp_en = '0;
            exp_k  = -1;
            for (int k = 0; k < 40; k++) begin
                t0 = 2 + 5*k + ((k >= stall_round) ? stall_len : 0);
                if ((c >= t0) && (c < t0 + 5)) begin
                    exp_en = 5'(1 << (c - t0));
                    exp_k  = k;
                end
            end
            chk("en",   32'(en),   32'(exp_en));
            chk("done", 32'(done), 32'(c == done_c));
            chk("busy", 32'(busy), 32'((c >= 1) && (c < done_c)));
            if (exp_k >= 0) begin
                chk("round",    32'(round),    32'(exp_k));
                chk("rnd_cnst", 32'(rnd_cnst), 32'(RC_TAB[exp_k]));
            end
            if (c == 1)          chk("ld_first",    32'(rnd_ld),      32'd1);
            if (c == done_c)     chk("final_rc",    32'(rnd_cnst),    32'h1a);
            if (c == done_c + 1) chk("ready_again", 32'(start_ready), 32'd1);
            ld_cnt += int'(rnd_ld);
            tick();
        end
        start = 1'b0;
        chk("ld_count", 32'(ld_cnt), 32'd40);
        chk("idle_after", 32'(busy), 32'd0);
    endtask

    initial begin
        int ld1;
        rst_n    = 1'b0;
        start    = 1'b0;
        abort    = 1'b0;
        rnd_ack  = 1'b0;
        start1   = 1'b0;
        abort1   = 1'b0;
        rnd_ack1 = 1'b0;
        repeat (2) tick();
        chk_reset_values("rst");
        rst_n = 1'b1;
        tick();
        chk_reset_values("post_rst");

        run_seq(99, 0, 1'b0);
        repeat (2) tick();
        run_seq(5, 3, 1'b0);
        repeat (2) tick();
        run_seq(99, 0, 1'b1);
        repeat (2) tick();

        // Abort in round 10, phase 2.
        cyc     = 0;
        start   = 1'b1;
        rnd_ack = 1'b1;
        tick();
        start = 1'b0;
        for (int c = 1; c < 54; c++) tick();
        cyc = 54;
        chk("pre_abort_en",    32'(en),    32'b00100);
        chk("pre_abort_round", 32'(round), 32'd10);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        cyc   = 55;
        #1;
        chk("abort_en",       32'(en),          32'd0);
        chk("abort_ready",    32'(start_ready), 32'd1);
        chk("abort_busy",     32'(busy),        32'd0);
        chk("abort_rnd_req",  32'(rnd_req),     32'd0);
        chk("abort_round",    32'(round),       32'd10);
        chk("abort_rnd_cnst", 32'(rnd_cnst),    32'(RC_TAB[10]));
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("abort_no_done", 32'(done), 32'd0);
        end
        abort = 1'b1;
        start = 1'b1;
        tick();
        abort = 1'b0;
        start = 1'b0;
        #1;
        chk("abort_beats_start", 32'(start_ready), 32'd1);
        chk("abort_beats_busy",  32'(busy),        32'd0);
        tick();
        run_seq(99, 0, 1'b0);
        repeat (2) tick();

        // Asynchronous reset in the middle of RUN.
        start   = 1'b1;
        rnd_ack = 1'b1;
        tick();
        start = 1'b0;
        repeat (20) tick();
        cyc = 21;
        chk("pre_rst_busy", 32'(busy), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        chk_reset_values("async");
        rnd_ack = 1'b0;
        #1;
        rnd_ack = 1'b1;
        #1;
        chk("rst_ack_no_ld", 32'(rnd_ld), 32'd0);
        tick();
        rst_n = 1'b1;
        tick();
        rnd_ack = 1'b1;
        #1;
        chk("idle_ack_no_req", 32'(rnd_req), 32'd0);
        chk("idle_ack_no_ld",  32'(rnd_ld),  32'd0);
        rnd_ack = 1'b0;
        tick();

        // Single-round instance.
        ld1      = 0;
        cyc      = 0;
        start1   = 1'b1;
        rnd_ack1 = 1'b1;
        tick();
        start1 = 1'b0;
        for (int c = 1; c <= 9; c++) begin
            cyc = c;
            #1;
            chk("nr1_en",   32'(en1),   ((c >= 2) && (c <= 6)) ? (32'd1 << (c - 2)) : 32'd0);
            chk("nr1_done", 32'(done1), 32'(c == 7));
            if (c == 6) begin
                chk("nr1_round",    32'(round1),    32'd0);
                chk("nr1_rnd_cnst", 32'(rnd_cnst1), 32'h01);
            end
            ld1 += int'(rnd_ld1);
            tick();
        end
        chk("nr1_ld_count", 32'(ld1), 32'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/dom1_skinny_round_sched.md
# dom1_skinny_round_sched

Round scheduler for the first-order DOM-masked SKINNY-128-384+ round datapath. It accepts a start request and sequences the 40 rounds, each as five one-hot phase enables. Before every round it fetches one fresh-randomness word from an external PRNG over a req/ack handshake, stalling the datapath while randomness is missing. It also drives the 6-bit round-constant LFSR and emits a single-cycle completion pulse. It sits between the byte-serial I/O FSM and the masked round datapath, replacing free-running enable rotation with a stall-capable sequencer.

## Interface
- NUM_ROUNDS, 40, rounds per encryption (1..63)
- RC_INIT, 6'h01, round constant for round 0
- clk  in  1  single clock; all state on rising edge
- rst  in  1  asynchronous, active-low reset
- start  in  1  request to begin an encryption; accepted only when start_ready=1
- start_ready  out  1  high exactly in IDLE
- abort  in  1  synchronous cancel, any state
- rnd_req  out  1  request fresh mask randomness for the next round
- rnd_ack  in  1  PRNG has a word; a transfer occurs when rnd_req&rnd_ack
- rnd_ld  out  1  combinational rnd_req&rnd_ack; datapath latches randomness
- en  out  5  one-hot phase enable; 5'b0 when stalled or idle
- rnd_cnst  out  6  round constant of the current round
- round  out  6  current round index, 0..NUM_ROUNDS-1
- busy  out  1  high in WAIT_RND and RUN
- done  out  1  single-cycle pulse after the final phase of the last round

## Operation
- States: IDLE, WAIT_RND, RUN, DONE.
- IDLE: start_ready=1. On start, go to WAIT_RND and set round=0, rnd_cnst=RC_INIT.
- WAIT_RND: rnd_req=1 and en=0. On rnd_ack, go to RUN with en=5'b00001.
- RUN: en rotates left one position per cycle.
- At en[4] in a non-final round:
  - rnd_req=1 (prefetch).
  - round increments and rnd_cnst steps: rnd_cnst <= {rc[4:0], rc[5]^rc[4]^1}.
  - If rnd_ack=1 in this cycle, the next cycle stays in RUN with en=00001 (zero bubble).
  - Otherwise the next cycle goes to WAIT_RND with en=0.
- At en[4] of the final round (round==NUM_ROUNDS-1): rnd_req=0, go to DONE. round and rnd_cnst hold.
- DONE: done=1 for one cycle, then IDLE. start is ignored in DONE.
- abort=1 in any state: go to IDLE next cycle with en=0, rnd_req=0, no done pulse. round and rnd_cnst hold their values. abort beats a simultaneous start.
- rnd_ack while rnd_req=0 is ignored; no transfer occurs.
- With RC_INIT=6'h01 and 40 rounds, the final-round rnd_cnst is 6'h1a.

## Timing
- Reset values: state=IDLE, start_ready=1, en=0, rnd_req=0, done=0, busy=0, round=0, rnd_cnst=RC_INIT.
- Cycle numbering, with rnd_ack constantly high and start accepted at cycle 0:
  - Cycle 1: WAIT_RND.
  - Round k en[0] at cycle 2+5k; round 39 en[4] at cycle 201.
  - done at cycle 202; start_ready again at cycle 203.
- Each cycle of rnd_ack low while rnd_req=1 adds exactly one stall cycle with en=0.
- Every output except rnd_ld is registered or decoded from state only.
- Exactly NUM_ROUNDS rnd_ld pulses occur per completed encryption.
- Reset asserted mid-run forces the reset values immediately. It is not a synchronous clear.

## Structure
- Shared package dom1_skinny_pkg holds:
  - state encoding (2 bits)
  - SKINNY_PHASES=5
  - RC_INIT and RC_LAST constants
  - the rc_step function (LFSR update)
- Sub-module dom1_skinny_rc_lfsr: 6-bit LFSR with async reset, load(RC_INIT) and step inputs. It is shared with future key-schedule controllers.
- Everything else is a single FSM plus the phase shift register.

## Test plan
- Nominal run, rnd_ack tied high, start at cycle 0:
  - en sequence is 00001..10000 repeated 40 times with no gaps.
  - 40 rnd_ld pulses, first at cycle 1.
  - rnd_cnst in the last round = 6'h1a.
  - done only at cycle 202.
- Randomness stall: rnd_ack low for 3 cycles before round 5 -> en=0 for exactly 3 cycles; done at cycle 205; rnd_cnst sequence unchanged.
- Abort at round 10 phase 2 -> next cycle IDLE, en=0, start_ready=1, no done; a fresh start then completes normally with rnd_cnst restarting at 6'h01.
- Start during busy and during DONE -> ignored; no second run and no extra rnd_ld.
- Async reset mid-RUN -> all outputs take reset values in the same cycle; rnd_ack pulses while rnd_req=0 produce no rnd_ld.
- NUM_ROUNDS=1 -> 5 en pulses, 1 rnd_ld, done at cycle 7.
